// File: rtl/i2s_receiver_if.sv
// rtl/i2s_receiver_if.sv - sample stream from the I2S receiver to its consumer
interface i2s_receiver_if #(
  parameter int width = 16
);
  logic             o_valid;
  logic             o_ready;
  logic             o_is_left;
  logic [width-1:0] o_audio;
  logic             o_overrun;

  modport master (
    output o_valid,
    output o_is_left,
    output o_audio,
    output o_overrun,
    input  o_ready
  );

  modport slave (
    input  o_valid,
    input  o_is_left,
    input  o_audio,
    input  o_overrun,
    output o_ready
  );
endinterface

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - oversampled I2S receiver; deserialises left/right words
// into left-aligned samples on a valid/ready stream with overrun reporting.
module i2s_receiver #(
  parameter int width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  i2s_receiver_if.master        smp
);

  localparam int             CW      = $clog2(width + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(width);

  logic [2:0]       sck_q;
  logic [1:0]       ws_q;
  logic [1:0]       sd_q;
  logic             sck_rise;
  logic             ws_s;
  logic             sd_s;

  logic [width-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ws_last_q, ws_last_d;
  logic             synced_q, synced_d;
  logic             done_q, done_d;
  logic [width-1:0] done_word_q, done_word_d;
  logic             done_left_q, done_left_d;
  logic [width-1:0] bit_word;

  logic             valid_q, valid_d;
  logic             is_left_q, is_left_d;
  logic [width-1:0] audio_q, audio_d;
  logic             overrun_q, overrun_d;

  // sd and ws share the sck pipeline depth so the sampled bit lines up with the edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_q <= '0;
      ws_q  <= '0;
      sd_q  <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      ws_q  <= {ws_q[0], ws};
      sd_q  <= {sd_q[0], sd};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign ws_s     = ws_q[1];
  assign sd_s     = sd_q[1];

  always_comb begin
    bit_word = shift_q;
    for (int i = 0; i < width; i++) begin
      if (int'(cnt_q) == width - 1 - i) bit_word[i] = sd_s;
    end
  end

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ws_last_d   = ws_last_q;
    synced_d    = synced_q;
    done_d      = 1'b0;
    done_word_d = done_word_q;
    done_left_d = done_left_q;
    if (sck_rise) begin
      if (ws_s == ws_last_q) begin
        shift_d = bit_word;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      end else begin
        // the bit carried with the ws change is the LSB of the word just ended
        done_d      = synced_q;
        done_word_d = bit_word;
        done_left_d = ~ws_last_q;
        shift_d     = '0;
        cnt_d       = '0;
        ws_last_d   = ws_s;
        synced_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      ws_last_q   <= 1'b0;
      synced_q    <= 1'b0;
      done_q      <= 1'b0;
      done_word_q <= '0;
      done_left_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ws_last_q   <= ws_last_d;
      synced_q    <= synced_d;
      done_q      <= done_d;
      done_word_q <= done_word_d;
      done_left_q <= done_left_d;
    end
  end

  // a word arriving while the held sample is still unaccepted is dropped
  always_comb begin
    valid_d   = valid_q;
    is_left_d = is_left_q;
    audio_d   = audio_q;
    overrun_d = 1'b0;
    if (done_q) begin
      if (!valid_q || smp.o_ready) begin
        valid_d   = 1'b1;
        is_left_d = done_left_q;
        audio_d   = done_word_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && smp.o_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      is_left_q <= 1'b0;
      audio_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      is_left_q <= is_left_d;
      audio_q   <= audio_d;
      overrun_q <= overrun_d;
    end
  end

  assign smp.o_valid   = valid_q;
  assign smp.o_is_left = is_left_q;
  assign smp.o_audio   = audio_q;
  assign smp.o_overrun = overrun_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - directed bench for i2s_receiver
module tb_i2s_receiver;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sck = 1'b0;
  logic ws = 1'b0;
  logic sd = 1'b0;

  i2s_receiver_if #(.width(W)) bus ();

  i2s_receiver #(.width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .sck   (sck),
    .ws    (ws),
    .sd    (sd),
    .smp   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [16:0] got[$];
  int          ovr_cnt = 0;
  int          hold_err = 0;
  int          gap_cnt = 0;
  int          vis_cnt = 0;
  logic        hold_prev = 1'b0;
  logic [16:0] prev_out = '0;
  logic        watch_gap = 1'b0;
  logic        watch_vis = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (hold_prev && ({bus.o_is_left, bus.o_audio} !== prev_out)) hold_err++;
      hold_prev = bus.o_valid && !bus.o_ready;
      prev_out  = {bus.o_is_left, bus.o_audio};
      if (bus.o_valid && bus.o_ready) got.push_back({bus.o_is_left, bus.o_audio});
      if (bus.o_overrun) ovr_cnt++;
      if (watch_gap && !bus.o_valid) gap_cnt++;
      if (watch_vis && bus.o_valid) vis_cnt++;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic sck_bit(input logic w, input logic d);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    #20;
    sck = 1'b1;
    #20;
  endtask

  task automatic send_head(input logic ch, input logic [31:0] data, input int nbits);
    for (int k = 0; k < nbits - 1; k++) sck_bit(ch, data[nbits-1-k]);
  endtask

  task automatic send_slot(input logic ch, input logic [31:0] data, input int nbits);
    send_head(ch, data, nbits);
    sck_bit(~ch, data[0]);
  endtask

  task automatic last_rise(input logic ch, input logic d);
    sck = 1'b0;
    ws  = ~ch;
    sd  = d;
    #20;
    sck = 1'b1;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          ovr0;
    int          lat;
    int          errs;
    logic [15:0] l, r;
    logic [16:0] ea[4];
    logic [16:0] expq[$];

    bus.o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.o_valid, 0);
    check("rst_audio", bus.o_audio, 0);
    check("rst_is_left", bus.o_is_left, 0);
    check("rst_overrun", bus.o_overrun, 0);
    reset = 1'b1;
    @(posedge clk);
    #3;

    // stereo 16-bit frames; first left word is only a sync point
    base = got.size();
    send_slot(0, 32'h8001, 16);
    send_slot(1, 32'h7FFE, 16);
    send_slot(0, 32'h8001, 16);
    send_slot(1, 32'h7FFE, 16);
    send_slot(0, 32'h8001, 16);
    settle();
    check("stereo_count", got.size() - base, 4);
    ea = '{17'h07FFE, 17'h18001, 17'h07FFE, 17'h18001};
    for (int i = 0; i < 4; i++) check($sformatf("stereo_word%0d", i), got[base+i], ea[i]);

    // long slots truncate, short slots zero-fill
    base = got.size();
    send_slot(1, 32'hCAFE0001, 32);
    send_slot(0, 32'h1234ABCD, 32);
    send_slot(1, 32'h0000005A, 8);
    send_slot(0, 32'h000000A5, 8);
    settle();
    check("width_count", got.size() - base, 4);
    ea = '{17'h0CAFE, 17'h11234, 17'h05A00, 17'h1A500};
    for (int i = 0; i < 4; i++) check($sformatf("width_word%0d", i), got[base+i], ea[i]);

    // backpressure: latency of first word, second word dropped
    bus.o_ready = 1'b0;
    ovr0 = ovr_cnt;
    send_head(1, 32'h1111, 16);
    last_rise(1, 1'b1);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!bus.o_valid && lat < 12);
    check("latency", lat, 4);
    send_slot(0, 32'h2222, 16);
    settle();
    check("hold_valid", bus.o_valid, 1);
    check("hold_audio", bus.o_audio, 32'h1111);
    check("hold_is_left", bus.o_is_left, 0);
    check("overrun_pulses", ovr_cnt - ovr0, 1);
    check("hold_stable", hold_err, 0);
    base = got.size();
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.o_ready = 1'b0;
    check("accept_clears_valid", bus.o_valid, 0);
    check("accept_keeps_audio", bus.o_audio, 32'h1111);
    check("accept_word", got[base], 17'h01111);

    // ready asserted exactly in the completion cycle
    send_slot(1, 32'h3333, 16);
    settle();
    base = got.size();
    ovr0 = ovr_cnt;
    send_head(0, 32'h4444, 16);
    last_rise(0, 1'b0);
    watch_gap = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.o_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    watch_gap = 1'b0;
    check("swap_no_gap", gap_cnt, 0);
    check("swap_no_overrun", ovr_cnt - ovr0, 0);
    check("swap_audio", bus.o_audio, 32'h4444);
    check("swap_is_left", bus.o_is_left, 1);
    check("swap_accepted", got[base], 17'h03333);
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset mid-left-word; next boundary only re-syncs
    send_slot(1, 32'h5555, 16);
    for (int k = 0; k < 5; k++) sck_bit(0, 1'b0);
    settle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_audio", bus.o_audio, 0);
    reset = 1'b1;
    base = got.size();
    watch_vis = 1'b1;
    for (int k = 5; k < 15; k++) sck_bit(0, 1'b1);
    sck_bit(1, 1'b1);
    settle();
    watch_vis = 1'b0;
    check("resync_no_emit", vis_cnt, 0);
    send_slot(1, 32'h7777, 16);
    settle();
    check("resync_count", got.size() - base, 1);
    check("resync_word", got[base], 17'h07777);

    // random sck-to-clk phase, random data
    #($urandom_range(1, 9));
    base = got.size();
    for (int f = 0; f < 200; f++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      send_slot(0, {16'h0, l}, 16);
      expq.push_back({1'b1, l});
      send_slot(1, {16'h0, r}, 16);
      expq.push_back({1'b0, r});
    end
    settle();
    check("rand_count", got.size() - base, 400);
    errs = 0;
    for (int i = 0; i < 400; i++) if (got[base+i] !== expq[i]) errs++;
    check("rand_bit_errors", errs, 0);
    check("final_hold_stable", hold_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
